// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and widths for the data memory responder
package mem_pkg;

  localparam int MEM_WORD_W = 32;
  localparam int MEM_BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/sram_be_array.sv
// rtl/sram_be_array.sv - word array with byte-enable synchronous write and synchronous read
module sram_be_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [MEM_BE_W-1:0]   i_be,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [MEM_WORD_W-1:0] i_wdata,
  output logic [MEM_WORD_W-1:0] o_rdata
);

  logic [MEM_WORD_W-1:0] r_mem [DEPTH_WORDS];

  // Byte-lane write and read-before-write registered read of the addressed word
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < MEM_BE_W; b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    o_rdata <= r_mem[i_idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding load/store responder with wait states and error flags
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [31:0]           i_req_addr,
  input  logic [MEM_WORD_W-1:0] i_req_wdata,
  input  logic [MEM_BE_W-1:0]   i_req_be,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [MEM_WORD_W-1:0] o_rsp_rdata,
  output logic                  o_rsp_err
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic                  r_rsp_load;
  logic                  r_write;
  logic [31:0]           r_addr;
  logic [MEM_WORD_W-1:0] r_wdata;
  logic [MEM_BE_W-1:0]   r_be;

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_in_idle;
  logic                  w_write;
  logic [31:0]           w_addr;
  logic [MEM_WORD_W-1:0] w_wdata;
  logic [MEM_BE_W-1:0]   w_be;
  logic                  w_err;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_we;
  logic [MEM_WORD_W-1:0] w_rdata;

  // With zero wait states the commit lands on the accept edge, so the array
  // must see the live request fields in IDLE and the latched ones afterwards.
  assign w_in_idle = (r_state == ST_IDLE);
  assign w_accept  = i_reset && w_in_idle && r_req_ready && i_req_valid;
  assign w_commit  = (w_accept && (WAIT_CYCLES == 0)) || ((r_state == ST_WAIT) && (r_cnt == 4'd0));
  assign w_write   = w_in_idle ? i_req_write : r_write;
  assign w_addr    = w_in_idle ? i_req_addr  : r_addr;
  assign w_wdata   = w_in_idle ? i_req_wdata : r_wdata;
  assign w_be      = w_in_idle ? i_req_be    : r_be;

  // Misaligned or beyond the array: any address bit above the index range set
  assign w_err = (w_addr[1:0] != 2'b00) || (w_addr[31:IDX_W+2] != '0);
  assign w_idx = w_addr[IDX_W+1:2];
  assign w_we  = w_commit && w_write && !w_err;

  sram_be_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .i_clk  (i_clk),
    .i_we   (w_we),
    .i_be   (w_be),
    .i_idx  (w_idx),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );

  // Request/response FSM with registered handshake outputs and commit-time status capture
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_load  <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write     <= i_req_write;
            r_addr      <= i_req_addr;
            r_wdata     <= i_req_wdata;
            r_be        <= i_req_be;
            r_req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_err;
              r_rsp_load  <= !w_write && !w_err;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_load  <= !w_write && !w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Array output is only exposed for a good load; it is stable in RESP since nothing writes then
  assign o_rsp_rdata = r_rsp_load ? w_rdata : '0;
  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed table-driven bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        v0, v1, v3;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;

  logic        rdy0, rdy1, rdy3;
  logic        rv0, rv1, rv3;
  logic [31:0] rd0, rd1, rd3;
  logic        er0, er1, er3;

  int n_chk;
  int n_err;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_req_valid(v1), .o_req_ready(rdy1),
    .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(rv1), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rd1), .o_rsp_err(er1)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_req_valid(v0), .o_req_ready(rdy0),
    .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(rv0), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rd0), .o_rsp_err(er0)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut3 (
    .i_clk(clk), .i_reset(reset), .i_req_valid(v3), .o_req_ready(rdy3),
    .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(rv3), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rd3), .o_rsp_err(er3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_rv(input int s);
    case (s)
      0:       return rv0;
      3:       return rv3;
      default: return rv1;
    endcase
  endfunction

  function automatic logic [31:0] get_rd(input int s);
    case (s)
      0:       return rd0;
      3:       return rd3;
      default: return rd1;
    endcase
  endfunction

  function automatic logic get_er(input int s);
    case (s)
      0:       return er0;
      3:       return er3;
      default: return er1;
    endcase
  endfunction

  // One request to instance s; lat counts edges from the accept edge (which is edge 1) to rsp_valid
  task automatic txn(input int s, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    case (s)
      0:       v0 = 1'b1;
      3:       v3 = 1'b1;
      default: v1 = 1'b1;
    endcase
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0; v3 = 1'b0;
    lat = 1;
    while (!get_rv(s) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = get_rd(s);
    er = get_er(s);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    n_chk = 0;
    n_err = 0;
    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b0, 32'h22,  32'h0,        4'hF, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 32'h400, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'h0,   32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b1, 32'h0,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h0,   32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    vecs[11] = '{1'b1, 32'h3FC, 32'h0BADCAFE, 4'hF, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'h3FC, 32'h0,        4'hF, 32'h0BADCAFE, 1'b0};
    vecs[13] = '{1'b0, 32'h404, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[14] = '{1'b1, 32'h11,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[15] = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[16] = '{1'b1, 32'h8,   32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    vecs[17] = '{1'b0, 32'h8,   32'h0,        4'hF, 32'hA5A5A5A5, 1'b0};

    reset = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v3 = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(rdy1), 32'd1);
    chk("reset rsp_valid", 32'(rv1), 32'd0);
    chk("reset rsp_rdata", rd1, 32'h0);
    chk("reset rsp_err", 32'(er1), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      txn(1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
    end

    // Backpressure: load held in RESP for 5 cycles while another request waits
    @(negedge clk);
    rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = 32'h10; req_be = 4'hF;
    v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    lat = 1;
    while (!rv1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp latency", 32'(lat), 32'd2);
    req_addr = 32'h20;
    v1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d rsp_valid", k), 32'(rv1), 32'd1);
      chk($sformatf("bp%0d rdata", k), rd1, 32'hDEADBEEF);
      chk($sformatf("bp%0d err", k), 32'(er1), 32'd0);
      chk($sformatf("bp%0d req_ready", k), 32'(rdy1), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release rsp_valid", 32'(rv1), 32'd0);
    chk("bp release req_ready", 32'(rdy1), 32'd1);
    @(posedge clk); #1;
    chk("bp next accepted", 32'(rdy1), 32'd0);
    v1 = 1'b0;
    @(posedge clk); #1;
    chk("bp next rsp_valid", 32'(rv1), 32'd1);
    chk("bp next rdata", rd1, 32'h11BB33DD);
    @(posedge clk); #1;

    // Zero and three wait states: latency and data path
    txn(0, 1'b1, 32'h44, 32'h13579BDF, 4'hF, rd, er, lat);
    chk("w0 store latency", 32'(lat), 32'd1);
    chk("w0 store err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h44, 32'h0, 4'hF, rd, er, lat);
    chk("w0 load latency", 32'(lat), 32'd1);
    chk("w0 load rdata", rd, 32'h13579BDF);
    txn(0, 1'b0, 32'h45, 32'h0, 4'hF, rd, er, lat);
    chk("w0 misaligned err", 32'(er), 32'd1);
    txn(3, 1'b1, 32'h44, 32'h2468ACE0, 4'hF, rd, er, lat);
    chk("w3 store latency", 32'(lat), 32'd4);
    txn(3, 1'b0, 32'h44, 32'h0, 4'hF, rd, er, lat);
    chk("w3 load latency", 32'(lat), 32'd4);
    chk("w3 load rdata", rd, 32'h2468ACE0);

    // Reset during WAIT of a store drops the store
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h55; req_be = 4'hF;
    v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    chk("rst in wait rsp_valid", 32'(rv1), 32'd0);
    chk("rst in wait req_ready", 32'(rdy1), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("rst async req_ready", 32'(rdy1), 32'd1);
    chk("rst async rsp_valid", 32'(rv1), 32'd0);
    chk("rst async rdata", rd1, 32'h0);
    chk("rst async err", 32'(er1), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    txn(1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat);
    chk("rst dropped store rdata", rd, 32'hA5A5A5A5);
    chk("rst dropped store err", 32'(er), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
